// File: rtl/cpu19_pkg.sv
// Shared types and constants for the 19-bit CPU fetch path.
package cpu19_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 19;
  localparam int OPC_W  = 5;

  localparam int OPC_MSB = DATA_W - 1;
  localparam int OPC_LSB = DATA_W - OPC_W;

  localparam logic [OPC_W-1:0] HALT_OPC = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLRPC,
    S_REQ,
    S_ISSUE,
    S_HALT,
    S_ERR
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_19bit_if.sv
// PC control, memory read and execute handoff signals of the fetch stage.
interface fetch_sequencer_19bit_if
  import cpu19_pkg::*;
  ();

  logic              START;
  logic [ADDR_W-1:0] PC_VAL;
  logic              PC_LOAD;
  logic              PC_INC;
  logic              PC_CLR;
  logic [ADDR_W-1:0] PC_DIN;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_ACK;
  logic [DATA_W-1:0] IR;
  logic              IR_VALID;
  logic              EX_READY;
  logic              BR_TAKEN;
  logic [ADDR_W-1:0] BR_TARGET;
  logic              HALTED;
  logic              ERR;

  modport slave (
    input  START, PC_VAL, MEM_RDATA, MEM_ACK,
    input  EX_READY, BR_TAKEN, BR_TARGET,
    output PC_LOAD, PC_INC, PC_CLR, PC_DIN,
    output MEM_REQ, MEM_ADDR, IR, IR_VALID,
    output HALTED, ERR
  );

  modport master (
    output START, PC_VAL, MEM_RDATA, MEM_ACK,
    output EX_READY, BR_TAKEN, BR_TARGET,
    input  PC_LOAD, PC_INC, PC_CLR, PC_DIN,
    input  MEM_REQ, MEM_ADDR, IR, IR_VALID,
    input  HALTED, ERR
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// 8-bit wait counter flagging when a memory request has waited too long.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/fetch_sequencer_19bit.sv
// Fetch control stage: drives PC strobes, reads memory, hands IR to execute.
module fetch_sequencer_19bit
  import cpu19_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  fetch_sequencer_19bit_if.slave  bus
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic              pc_load, pc_inc, pc_clr;
  logic [ADDR_W-1:0] pc_din, mem_addr;
  logic              mem_req;
  logic              tmo_clr, tmo_en, tmo_exp;
  logic              is_halt;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  assign is_halt = (ir_q[OPC_MSB:OPC_LSB] == HALT_OPC);

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_clr   = 1'b0;
    pc_din   = '0;
    mem_req  = 1'b0;
    mem_addr = '0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START)
          state_d = S_CLRPC;
      end
      S_CLRPC: begin
        pc_clr  = 1'b1;
        tmo_clr = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = bus.PC_VAL;
        if (bus.MEM_ACK) begin
          ir_d    = bus.MEM_RDATA;
          pc_inc  = 1'b1;
          tmo_clr = 1'b1;
          state_d = S_ISSUE;
        end else if (tmo_exp) begin
          state_d = S_ERR;
        end else begin
          tmo_en = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.EX_READY) begin
          if (is_halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
            // branch target lands in the PC on the handshake edge
            if (bus.BR_TAKEN) begin
              pc_load = 1'b1;
              pc_din  = bus.BR_TARGET;
            end
          end
        end
      end
      S_HALT: begin
        if (bus.START)
          state_d = S_REQ;
      end
      S_ERR: begin
        if (bus.START)
          state_d = S_CLRPC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.PC_LOAD  = pc_load;
  assign bus.PC_INC   = pc_inc;
  assign bus.PC_CLR   = pc_clr;
  assign bus.PC_DIN   = pc_din;
  assign bus.MEM_REQ  = mem_req;
  assign bus.MEM_ADDR = mem_addr;
  assign bus.IR       = ir_q;
  assign bus.IR_VALID = (state_q == S_ISSUE);
  assign bus.HALTED   = (state_q == S_HALT);
  assign bus.ERR      = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_sequencer_19bit.sv
// Directed plus randomized bench for fetch_sequencer_19bit with a PC model.
module tb_fetch_sequencer_19bit;

  localparam int TMO = 15;

  logic CLK = 1'b0;
  logic RST_N;

  fetch_sequencer_19bit_if bus ();

  fetch_sequencer_19bit #(.TIMEOUT(TMO)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [18:0] pc_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           pc_reg <= '0;
    else if (bus.PC_CLR)  pc_reg <= '0;
    else if (bus.PC_LOAD) pc_reg <= bus.PC_DIN;
    else if (bus.PC_INC)  pc_reg <= pc_reg + 19'd1;
  end

  assign bus.PC_VAL = pc_reg;

  int nvec = 0;
  int nerr = 0;

  logic [18:0] exp_pc;
  logic [18:0] exp_ir;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      chk("strobe_excl",
          32'(bus.PC_LOAD) + 32'(bus.PC_INC) + 32'(bus.PC_CLR) <= 1, 1);
      if (!bus.PC_LOAD)
        chk("pc_din_zero", 32'(bus.PC_DIN), 0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [18:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      #2;
      chk("req_wait", 32'(bus.MEM_REQ), 1);
      chk("addr_wait", 32'(bus.MEM_ADDR), 32'(exp_pc));
      chk("inc_wait", 32'(bus.PC_INC), 0);
      step();
    end
    bus.MEM_ACK   = 1'b1;
    bus.MEM_RDATA = data;
    #2;
    chk("req_ack", 32'(bus.MEM_REQ), 1);
    chk("addr_ack", 32'(bus.MEM_ADDR), 32'(exp_pc));
    chk("inc_ack", 32'(bus.PC_INC), 1);
    step();
    bus.MEM_ACK   = 1'b0;
    bus.MEM_RDATA = 19'($urandom);
    exp_ir = data;
    exp_pc = exp_pc + 19'd1;
  endtask

  task automatic issue(input int hold, input bit br, input logic [18:0] tgt);
    bit halt;
    bit ld;
    halt = (exp_ir[18:14] == 5'h1F);
    ld   = br && !halt;
    #2;
    chk("pc_issue", 32'(bus.PC_VAL), 32'(exp_pc));
    for (int i = 0; i < hold; i++) begin
      bus.EX_READY = 1'b0;
      #1;
      chk("ir_hold", 32'(bus.IR), 32'(exp_ir));
      chk("irv_hold", 32'(bus.IR_VALID), 1);
      chk("req_hold", 32'(bus.MEM_REQ), 0);
      step();
      #1;
    end
    bus.EX_READY  = 1'b1;
    bus.BR_TAKEN  = br;
    bus.BR_TARGET = tgt;
    #1;
    chk("ir_hs", 32'(bus.IR), 32'(exp_ir));
    chk("irv_hs", 32'(bus.IR_VALID), 1);
    chk("load_hs", 32'(bus.PC_LOAD), 32'(ld));
    chk("din_hs", 32'(bus.PC_DIN), ld ? 32'(tgt) : 0);
    step();
    bus.EX_READY  = 1'b0;
    bus.BR_TAKEN  = 1'b0;
    bus.BR_TARGET = 19'($urandom);
    if (ld) exp_pc = tgt;
    if (halt) begin
      #2;
      chk("halted", 32'(bus.HALTED), 1);
      chk("req_halt", 32'(bus.MEM_REQ), 0);
      chk("irv_halt", 32'(bus.IR_VALID), 0);
      step();
    end
  endtask

  task automatic resume();
    bus.START = 1'b1;
    #2;
    chk("halted_pre", 32'(bus.HALTED), 1);
    chk("clr_resume", 32'(bus.PC_CLR), 0);
    step();
    bus.START = 1'b0;
  endtask

  initial begin
    logic [18:0] d;
    logic [4:0]  opc;
    RST_N         = 1'b0;
    bus.START     = 1'b0;
    bus.MEM_RDATA = '0;
    bus.MEM_ACK   = 1'b0;
    bus.EX_READY  = 1'b0;
    bus.BR_TAKEN  = 1'b0;
    bus.BR_TARGET = '0;
    exp_pc        = '0;
    exp_ir        = '0;

    #3;
    chk("rst_req", 32'(bus.MEM_REQ), 0);
    chk("rst_ir", 32'(bus.IR), 0);
    chk("rst_irv", 32'(bus.IR_VALID), 0);
    chk("rst_din", 32'(bus.PC_DIN), 0);
    chk("rst_halted", 32'(bus.HALTED), 0);
    chk("rst_err", 32'(bus.ERR), 0);
    step();
    RST_N = 1'b1;
    step();

    // stray ack in idle must not load IR
    bus.MEM_ACK   = 1'b1;
    bus.MEM_RDATA = 19'h5555;
    step();
    bus.MEM_ACK = 1'b0;
    #2;
    chk("idle_ir", 32'(bus.IR), 0);
    chk("idle_req", 32'(bus.MEM_REQ), 0);
    chk("idle_clr", 32'(bus.PC_CLR), 0);
    step();

    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    #2;
    chk("clrpc", 32'(bus.PC_CLR), 1);
    chk("req_clrpc", 32'(bus.MEM_REQ), 0);
    step();
    exp_pc = '0;
    fetch(19'h0A123, 2);
    issue(5, 1'b0, '0);
    fetch(19'h01234, 1);
    issue(0, 1'b1, 19'h00400);
    fetch(19'h02222, 0);
    issue(1, 1'b1, 19'h00007);
    fetch({5'h1F, 14'h0ABC}, 3);
    issue(2, 1'b1, 19'h00100);
    step();
    #2;
    chk("halt_stay", 32'(bus.HALTED), 1);
    step();
    resume();
    fetch(19'h03333, 1);
    issue(0, 1'b0, '0);

    for (int k = 0; k < 24; k++) begin
      opc = 5'($urandom);
      if (k % 6 == 5)       opc = 5'h1F;
      else if (opc == 5'h1F) opc = 5'h00;
      d = {opc, 14'($urandom)};
      fetch(d, int'($urandom_range(0, 4)));
      issue(int'($urandom_range(0, 3)), ($urandom % 3) == 0, 19'($urandom));
      if (opc == 5'h1F) resume();
    end

    for (int i = 0; i < TMO; i++) begin
      #2;
      chk("tmo_req", 32'(bus.MEM_REQ), 1);
      chk("tmo_noerr", 32'(bus.ERR), 0);
      step();
    end
    #2;
    chk("tmo_err", 32'(bus.ERR), 1);
    chk("tmo_req_off", 32'(bus.MEM_REQ), 0);
    step();
    bus.MEM_ACK   = 1'b1;
    bus.MEM_RDATA = 19'h7FFFF;
    step();
    bus.MEM_ACK = 1'b0;
    #2;
    chk("late_ack_err", 32'(bus.ERR), 1);
    chk("late_ack_ir", 32'(bus.IR), 32'(exp_ir));
    step();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    #2;
    chk("err_clrpc", 32'(bus.PC_CLR), 1);
    step();
    exp_pc = '0;
    fetch(19'h04444, 2);
    issue(0, 1'b0, '0);

    #2;
    chk("pre_rst_req", 32'(bus.MEM_REQ), 1);
    RST_N = 1'b0;
    #1;
    chk("arst_req", 32'(bus.MEM_REQ), 0);
    chk("arst_irv", 32'(bus.IR_VALID), 0);
    chk("arst_inc", 32'(bus.PC_INC), 0);
    chk("arst_clr", 32'(bus.PC_CLR), 0);
    chk("arst_load", 32'(bus.PC_LOAD), 0);
    chk("arst_ir", 32'(bus.IR), 0);
    step();
    RST_N = 1'b1;
    step();
    step();
    #2;
    chk("post_rst_req", 32'(bus.MEM_REQ), 0);
    chk("post_rst_clr", 32'(bus.PC_CLR), 0);
    chk("post_rst_halt", 32'(bus.HALTED), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
